riscv_lsu: RTL and testbench

//  Load/store unit directly downstream of the execute-stage ALU. Takes the ALU result as the effective address.

---
 rtl/riscv_lsu_pkg.sv | 36 +++
 rtl/riscv_lsu_align.sv | 55 +++++
 rtl/riscv_lsu.sv | 139 +++++++++++++
 tb/tb_riscv_lsu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RISC-V load/store unit.
// Covers funct3 encodings, FSM states and the access-size byte mask helper.
package riscv_lsu_pkg;

  localparam int XLEN = 64;
  localparam int BE_W = XLEN / 8;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Byte mask of an access of size 2**size, anchored at lane 0.
  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] size);
    logic [BE_W-1:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational byte-lane steering for the LSU: store byte enables and data shift,
// misalignment detection, and load extract with sign/zero extension.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_offset,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_sh,
  output logic            misalign,
  output logic [XLEN-1:0] ld_result
);

  logic [XLEN-1:0] ld_sh_s;

  assign be       = size_mask(funct3[1:0]) << offset;
  assign wdata_sh = wdata << {offset, 3'b000};
  assign ld_sh_s  = mem_rdata >> {ld_offset, 3'b000};

  // Natural-alignment check; the reserved encoding never faults, it completes without access.
  always_comb begin
    misalign = 1'b0;
    if (funct3 == F3_ILL) begin
      misalign = 1'b0;
    end else begin
      case (funct3[1:0])
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = offset[0];
        2'b10:   misalign = |offset[1:0];
        2'b11:   misalign = |offset;
        default: misalign = 1'b0;
      endcase
    end
  end

  // Truncate the lane-shifted doubleword to the access size and extend.
  always_comb begin
    ld_result = 64'h0;
    case (ld_funct3)
      F3_B:    ld_result = {{56{ld_sh_s[7]}},  ld_sh_s[7:0]};
      F3_H:    ld_result = {{48{ld_sh_s[15]}}, ld_sh_s[15:0]};
      F3_W:    ld_result = {{32{ld_sh_s[31]}}, ld_sh_s[31:0]};
      F3_D:    ld_result = ld_sh_s;
      F3_BU:   ld_result = {56'h0, ld_sh_s[7:0]};
      F3_HU:   ld_result = {48'h0, ld_sh_s[15:0]};
      F3_WU:   ld_result = {32'h0, ld_sh_s[31:0]};
      default: ld_result = 64'h0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one data-memory transaction per instruction over req/ready + rvalid,
// stalling the pipeline until the access completes.
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic            i_riscv_lsu_clk,
  input  logic            i_riscv_lsu_rst,
  input  logic            i_riscv_lsu_valid,
  input  logic            i_riscv_lsu_load,
  input  logic [2:0]      i_riscv_lsu_funct3,
  input  logic [XLEN-1:0] i_riscv_lsu_addr,
  input  logic [XLEN-1:0] i_riscv_lsu_wdata,
  output logic            o_riscv_lsu_stall,
  output logic            o_riscv_lsu_done,
  output logic [XLEN-1:0] o_riscv_lsu_rdata,
  output logic            o_riscv_lsu_misalign,
  output logic            o_riscv_lsu_mem_req,
  output logic            o_riscv_lsu_mem_we,
  output logic [XLEN-1:0] o_riscv_lsu_mem_addr,
  output logic [BE_W-1:0] o_riscv_lsu_mem_be,
  output logic [XLEN-1:0] o_riscv_lsu_mem_wdata,
  input  logic            i_riscv_lsu_mem_ready,
  input  logic            i_riscv_lsu_mem_rvalid,
  input  logic [XLEN-1:0] i_riscv_lsu_mem_rdata
);

  lsu_state_t      state_r;
  logic [XLEN-1:0] addr_r;
  logic [2:0]      funct3_r;
  logic            we_r;
  logic [BE_W-1:0] be_r;
  logic [XLEN-1:0] wdata_r;
  logic            mem_req_r;
  logic            done_r;
  logic            misalign_r;
  logic [XLEN-1:0] rdata_r;

  logic [BE_W-1:0] be_s;
  logic [XLEN-1:0] wdata_sh_s;
  logic            misalign_s;
  logic [XLEN-1:0] ld_result_s;
  logic            illegal_s;

  // Store side works on the live EX inputs; load side on the registered request.
  riscv_lsu_align u_align (
    .funct3    (i_riscv_lsu_funct3),
    .offset    (i_riscv_lsu_addr[2:0]),
    .wdata     (i_riscv_lsu_wdata),
    .ld_funct3 (funct3_r),
    .ld_offset (addr_r[2:0]),
    .mem_rdata (i_riscv_lsu_mem_rdata),
    .be        (be_s),
    .wdata_sh  (wdata_sh_s),
    .misalign  (misalign_s),
    .ld_result (ld_result_s)
  );

  assign illegal_s = (i_riscv_lsu_funct3 == F3_ILL) |
                     (~i_riscv_lsu_load & i_riscv_lsu_funct3[2]);

  // Stall must react in the same cycle EX presents the access, so it is decoded from state.
  assign o_riscv_lsu_stall = ~i_riscv_lsu_rst &
                             (((state_r == IDLE) & i_riscv_lsu_valid & ~misalign_s) |
                              (state_r == REQ) | (state_r == WAIT));

  assign o_riscv_lsu_done      = done_r;
  assign o_riscv_lsu_rdata     = rdata_r;
  assign o_riscv_lsu_misalign  = misalign_r;
  assign o_riscv_lsu_mem_req   = mem_req_r;
  assign o_riscv_lsu_mem_we    = we_r;
  assign o_riscv_lsu_mem_addr  = {addr_r[XLEN-1:3], 3'b000};
  assign o_riscv_lsu_mem_be    = be_r;
  assign o_riscv_lsu_mem_wdata = wdata_r;

  // Transaction FSM with request, status and load-result registers.
  always_ff @(posedge i_riscv_lsu_clk) begin
    if (i_riscv_lsu_rst) begin
      state_r    <= IDLE;
      addr_r     <= 64'h0;
      funct3_r   <= 3'b000;
      we_r       <= 1'b0;
      be_r       <= 8'h00;
      wdata_r    <= 64'h0;
      mem_req_r  <= 1'b0;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      rdata_r    <= 64'h0;
    end else begin
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_riscv_lsu_valid) begin
            addr_r   <= i_riscv_lsu_addr;
            funct3_r <= i_riscv_lsu_funct3;
            we_r     <= ~i_riscv_lsu_load;
            be_r     <= be_s;
            wdata_r  <= wdata_sh_s;
            rdata_r  <= 64'h0;
            if (misalign_s) begin
              misalign_r <= 1'b1;
            end else if (illegal_s) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              mem_req_r <= 1'b1;
              state_r   <= REQ;
            end
          end
        end
        REQ: begin
          if (i_riscv_lsu_mem_ready) begin
            mem_req_r <= 1'b0;
            if (we_r) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_riscv_lsu_mem_rvalid) begin
            rdata_r <= ld_result_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: byte-level reference model plus a per-cycle compare
// process, directed scenarios with literal pins, then randomized transactions.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst, valid, load, ready, rvalid;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata, mem_rdata;
  logic        stall, done, misalign, mem_req, mem_we;
  logic [63:0] rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_be;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .i_riscv_lsu_clk        (clk),
    .i_riscv_lsu_rst        (rst),
    .i_riscv_lsu_valid      (valid),
    .i_riscv_lsu_load       (load),
    .i_riscv_lsu_funct3     (funct3),
    .i_riscv_lsu_addr       (addr),
    .i_riscv_lsu_wdata      (wdata),
    .o_riscv_lsu_stall      (stall),
    .o_riscv_lsu_done       (done),
    .o_riscv_lsu_rdata      (rdata),
    .o_riscv_lsu_misalign   (misalign),
    .o_riscv_lsu_mem_req    (mem_req),
    .o_riscv_lsu_mem_we     (mem_we),
    .o_riscv_lsu_mem_addr   (mem_addr),
    .o_riscv_lsu_mem_be     (mem_be),
    .o_riscv_lsu_mem_wdata  (mem_wdata),
    .i_riscv_lsu_mem_ready  (ready),
    .i_riscv_lsu_mem_rvalid (rvalid),
    .i_riscv_lsu_mem_rdata  (mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs for the current cycle, plus literal pins for directed cases.
  bit          chk_en = 1'b0;
  bit          e_zero, e_stall, e_done, e_mis, e_req, e_we, e_chk_rd;
  logic [63:0] e_addr, e_wdata, e_rdata;
  logic [7:0]  e_be;
  bit          p_req, p_rd;
  logic [63:0] p_addr, p_wdata, p_rdata;
  logic [7:0]  p_be;

  function automatic logic [7:0] m_be(input logic [2:0] f3, input logic [2:0] off);
    int n = 1 << f3[1:0];
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off) && i < int'(off) + n) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [2:0] off);
    logic [63:0] r = 64'h0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off)) r[8*i +: 8] = wd[8*(i - int'(off)) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [2:0] off,
                                         input logic [63:0] rd);
    int n = 1 << f3[1:0];
    logic [63:0] r = 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (i < n)
        r[8*i +: 8] = (int'(off) + i < 8) ? rd[8*(int'(off) + i) +: 8] : 8'h00;
      else
        r[8*i +: 8] = (!f3[2] && r[8*n - 1]) ? 8'hFF : 8'h00;
    end
    return r;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [2:0] off);
    if (f3 == 3'b111) return 1'b0;
    return (int'(off) % (1 << f3[1:0])) != 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Single compare process: every cycle, DUT outputs against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      if (e_zero) begin
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_misalign", 64'(misalign), 64'h0);
        chk("rst_req", 64'(mem_req), 64'h0);
        chk("rst_we", 64'(mem_we), 64'h0);
        chk("rst_addr", mem_addr, 64'h0);
        chk("rst_be", 64'(mem_be), 64'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        chk("rst_rdata", rdata, 64'h0);
      end else begin
        chk("stall", 64'(stall), 64'(e_stall));
        chk("done", 64'(done), 64'(e_done));
        chk("misalign", 64'(misalign), 64'(e_mis));
        chk("mem_req", 64'(mem_req), 64'(e_req));
        if (e_req) begin
          chk("mem_we", 64'(mem_we), 64'(e_we));
          chk("mem_addr", mem_addr, e_addr);
          chk("mem_be", 64'(mem_be), 64'(e_be));
          if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
          if (p_req) begin
            chk("pin_addr", mem_addr, p_addr);
            chk("pin_be", 64'(mem_be), 64'(p_be));
            if (e_we) chk("pin_wdata", mem_wdata, p_wdata);
          end
        end
        if (e_done && e_chk_rd) chk("rdata", rdata, e_rdata);
        if (e_done && p_rd) chk("pin_rdata", rdata, p_rdata);
      end
    end
  end

  task automatic clr_exp();
    e_zero = 0; e_stall = 0; e_done = 0; e_mis = 0; e_req = 0; e_we = 0; e_chk_rd = 0;
    p_req = 0; p_rd = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic noise_rvalid();
    rvalid    = 1'($urandom % 2);
    mem_rdata = {$urandom, $urandom};
  endtask

  // Occasional valid while busy; the DUT must ignore it.
  task automatic spur();
    valid  = ($urandom % 4) == 0;
    load   = 1'($urandom % 2);
    funct3 = 3'($urandom % 8);
    addr   = {$urandom, $urandom};
    wdata  = {$urandom, $urandom};
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      clr_exp(); valid = 0; noise_rvalid(); cyc();
    end
  endtask

  task automatic do_txn(input bit ld, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] rd,
                        input int rdly, input int vdly,
                        input bit pr, input logic [7:0] pbe, input logic [63:0] paddr,
                        input logic [63:0] pwd, input bit prd_en, input logic [63:0] prd);
    logic [2:0] off = a[2:0];
    bit mis = m_mis(f3, off);
    bit ill = (f3 == 3'b111) || (!ld && f3[2]);
    clr_exp();
    valid = 1; load = ld; funct3 = f3; addr = a; wdata = wd; ready = 0; noise_rvalid();
    e_stall = !mis;
    cyc();
    if (mis) begin
      clr_exp(); valid = 0; e_mis = 1; noise_rvalid(); cyc();
    end else if (ill) begin
      clr_exp(); spur(); noise_rvalid();
      e_done = 1; e_chk_rd = 1; e_rdata = 64'h0;
      cyc();
    end else begin
      for (int k = 0; k <= rdly; k++) begin
        clr_exp(); spur(); noise_rvalid();
        ready = (k == rdly);
        e_stall = 1; e_req = 1; e_we = !ld;
        e_addr = {a[63:3], 3'b000}; e_be = m_be(f3, off); e_wdata = m_wdata(wd, off);
        p_req = pr; p_be = pbe; p_addr = paddr; p_wdata = pwd;
        cyc();
      end
      ready = 0;
      if (ld) begin
        for (int k = 0; k <= vdly; k++) begin
          clr_exp(); spur();
          rvalid = (k == vdly);
          mem_rdata = rvalid ? rd : {$urandom, $urandom};
          e_stall = 1;
          cyc();
        end
      end
      clr_exp(); spur(); noise_rvalid();
      e_done = 1; e_chk_rd = ld; e_rdata = ld ? m_load(f3, off, rd) : 64'h0;
      p_rd = prd_en; p_rdata = prd;
      cyc();
    end
    valid = 0; rvalid = 0;
  endtask

  initial begin
    rst = 1; valid = 0; load = 0; funct3 = 3'b000; addr = 64'h0; wdata = 64'h0;
    ready = 0; rvalid = 0; mem_rdata = 64'h0;
    clr_exp();
    repeat (2) @(posedge clk);
    #1;
    // Reset held with a valid present: everything zero, stall gated.
    chk_en = 1; e_zero = 1; valid = 1; load = 1; funct3 = 3'b011; addr = 64'h40;
    cyc();
    rst = 0; valid = 0; e_zero = 1;
    cyc();

    // SB a=0x1003: be=0x08, wdata=0xAB<<24, addr=0x1000, done at cycle 2.
    do_txn(0, 3'b000, 64'h1003, 64'hAB, 64'h0, 0, 0,
           1, 8'h08, 64'h1000, 64'h0000_0000_AB00_0000, 0, 64'h0);
    gap(1);
    // LB / LBU at byte 5 holding 0x80.
    do_txn(1, 3'b000, 64'h2005, 64'h0, 64'h0000_80FF_0000_0000, 0, 1,
           1, 8'h20, 64'h2000, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF80);
    do_txn(1, 3'b100, 64'h2005, 64'h0, 64'h0000_80FF_0000_0000, 1, 0,
           0, 8'h00, 64'h0, 64'h0, 1, 64'h0000_0000_0000_0080);
    gap(1);
    // LW misaligned: single misalign pulse, no request, no stall.
    do_txn(1, 3'b010, 64'h2002, 64'h0, 64'h0, 0, 0, 0, 8'h00, 64'h0, 64'h0, 0, 64'h0);
    gap(1);
    // LD with ready low for 3 cycles and rvalid 2 cycles later.
    do_txn(1, 3'b011, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 2,
           1, 8'hFF, 64'h3000, 64'h0, 1, 64'h0123_4567_89AB_CDEF);
    // Reserved funct3 and a store with funct3>=100 complete with no access.
    do_txn(1, 3'b111, 64'h4000, 64'h0, 64'h0, 0, 0, 0, 8'h00, 64'h0, 64'h0, 1, 64'h0);
    do_txn(0, 3'b100, 64'h4000, 64'h55, 64'h0, 0, 0, 0, 8'h00, 64'h0, 64'h0, 0, 64'h0);
    gap(1);

    // Reset while waiting for read data: outputs clear, late rvalid ignored, no done.
    clr_exp(); valid = 1; load = 1; funct3 = 3'b011; addr = 64'h5000; e_stall = 1;
    cyc();
    clr_exp(); valid = 0; ready = 1; rvalid = 0;
    e_stall = 1; e_req = 1; e_we = 0; e_addr = 64'h5000; e_be = 8'hFF;
    cyc();
    clr_exp(); ready = 0; e_stall = 1;
    cyc();
    clr_exp(); rst = 1;
    cyc();
    clr_exp(); rst = 0; rvalid = 1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; e_zero = 1;
    cyc();
    clr_exp(); rvalid = 0; e_zero = 1;
    cyc();

    // Back-to-back SD then LWU a=0x8.
    do_txn(0, 3'b011, 64'h8, 64'h1122_3344_5566_7788, 64'h0, 0, 0,
           1, 8'hFF, 64'h8, 64'h1122_3344_5566_7788, 0, 64'h0);
    do_txn(1, 3'b110, 64'h8, 64'h0, 64'h8000_0001_8000_0001, 0, 0,
           0, 8'h00, 64'h0, 64'h0, 1, 64'h0000_0000_8000_0001);
    gap(2);

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      bit          ld = 1'($urandom % 2);
      logic [2:0]  f3 = 3'($urandom % 8);
      logic [63:0] a  = {$urandom, $urandom};
      logic [2:0]  m  = 3'((1 << f3[1:0]) - 1);
      if ($urandom % 3 != 0) a[2:0] = a[2:0] & ~m;
      do_txn(ld, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom % 4), int'($urandom % 4), 0, 8'h00, 64'h0, 64'h0, 0, 64'h0);
      gap(int'($urandom % 3));
    end

    chk_en = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
